// File: rtl/m2_irq_timer_pkg.sv
// Shared definitions for the m2 CPU-cycle IRQ timer.
// Mode codes, register offsets and save-state slot numbers.
package m2_irq_timer_pkg;

    typedef enum logic [1:0] {
        TMR_LEGACY  = 2'd0,
        TMR_ONESHOT = 2'd1,
        TMR_RELOAD  = 2'd2,
        TMR_RSVD    = 2'd3
    } tmr_mode_e;

    localparam logic [1:0] TMR_CTRL   = 2'd0;
    localparam logic [1:0] TMR_RLD_LO = 2'd1;
    localparam logic [1:0] TMR_RLD_HI = 2'd2;
    localparam logic [1:0] TMR_ACK    = 2'd3;

    localparam logic [2:0] SS_CTRL   = 3'd0;
    localparam logic [2:0] SS_CTR_LO = 3'd1;
    localparam logic [2:0] SS_CTR_HI = 3'd2;
    localparam logic [2:0] SS_RLD_LO = 3'd3;
    localparam logic [2:0] SS_RLD_HI = 3'd4;

    function automatic logic [7:0] ctrl_byte(
        input logic      pend,
        input tmr_mode_e mode,
        input logic      en
    );
        return {pend, 4'b0000, mode, en};
    endfunction

endpackage

// File: rtl/m2_irq_timer_ch.sv
// One timer channel: counter, reload, enable, mode, pending flag.
// Ports: i_m2/i_rst_n clock+reset; i_we/i_off/i_wdat decoded reg
//  write; i_ss_* save-state access; o_* status bytes and o_pend.
module m2_irq_timer_ch
    import m2_irq_timer_pkg::*;
#(
    parameter int CW = 13
) (
    input  logic       i_m2,
    input  logic       i_rst_n,
    input  logic       i_ss_act,
    input  logic       i_we,
    input  logic [1:0] i_off,
    input  logic [7:0] i_wdat,
    input  logic       i_ss_we,
    input  logic [2:0] i_ss_slot,
    input  logic [7:0] i_ss_wdat,
    output logic [7:0] o_ctrl,
    output logic [7:0] o_ctr_lo,
    output logic [7:0] o_ctr_hi,
    output logic [7:0] o_rld_lo,
    output logic [7:0] o_rld_hi,
    output logic       o_pend
);

    logic [CW-1:0] r_ctr, w_ctr_nx;
    logic [CW-1:0] r_rld, w_rld_nx;
    logic          r_en, w_en_nx;
    logic          r_pend, w_pend_nx;
    tmr_mode_e     r_mode, w_mode_nx;
    logic          w_term;

    always_comb begin
        w_ctr_nx  = r_ctr;
        w_rld_nx  = r_rld;
        w_en_nx   = r_en;
        w_mode_nx = r_mode;
        w_pend_nx = r_pend;
        w_term    = 1'b0;
        if (i_ss_act) begin
            if (i_ss_we) begin
                case (i_ss_slot)
                    SS_CTRL: begin
                        w_pend_nx = i_ss_wdat[7];
                        w_mode_nx = tmr_mode_e'(i_ss_wdat[2:1]);
                        w_en_nx   = i_ss_wdat[0];
                    end
                    SS_CTR_LO: w_ctr_nx[7:0] = i_ss_wdat;
                    SS_CTR_HI: w_ctr_nx[CW-1:8] = i_ss_wdat[CW-9:0];
                    SS_RLD_LO: w_rld_nx[7:0] = i_ss_wdat;
                    SS_RLD_HI: w_rld_nx[CW-1:8] = i_ss_wdat[CW-9:0];
                    default: ;
                endcase
            end
        end else begin
            // Reload value is updated first so a same-edge reload
            // picks up the freshly written value.
            if (i_we && i_off == TMR_RLD_LO)
                w_rld_nx[7:0] = i_wdat;
            if (i_we && i_off == TMR_RLD_HI)
                w_rld_nx[CW-1:8] = i_wdat[CW-9:0];
            if (r_en) begin
                if (r_mode == TMR_LEGACY) begin
                    if (r_ctr[CW-1]) begin
                        w_term  = 1'b1;
                        w_en_nx = 1'b0;
                    end else begin
                        w_ctr_nx = r_ctr + CW'(1);
                    end
                end else if (r_ctr == '0) begin
                    w_term = 1'b1;
                    if (r_mode == TMR_RELOAD)
                        w_ctr_nx = w_rld_nx;
                    else
                        w_en_nx = 1'b0;
                end else begin
                    w_ctr_nx = r_ctr - CW'(1);
                end
            end
            if (w_term)
                w_pend_nx = 1'b1;
            // Register writes override the fields they touch.
            if (i_we) begin
                case (i_off)
                    TMR_CTRL: begin
                        w_en_nx   = i_wdat[0];
                        w_mode_nx = tmr_mode_e'(i_wdat[2:1]);
                        if (!i_wdat[0] &&
                            i_wdat[2:1] == TMR_LEGACY) begin
                            w_ctr_nx  = '0;
                            w_pend_nx = 1'b0;
                        end
                    end
                    TMR_RLD_HI: w_ctr_nx = w_rld_nx;
                    TMR_ACK: begin
                        if (!w_term)
                            w_pend_nx = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(negedge i_m2 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ctr  <= '0;
            r_rld  <= '0;
            r_en   <= 1'b0;
            r_mode <= TMR_LEGACY;
            r_pend <= 1'b0;
        end else begin
            r_ctr  <= w_ctr_nx;
            r_rld  <= w_rld_nx;
            r_en   <= w_en_nx;
            r_mode <= w_mode_nx;
            r_pend <= w_pend_nx;
        end
    end

    assign o_ctrl   = ctrl_byte(r_pend, r_mode, r_en);
    assign o_ctr_lo = r_ctr[7:0];
    assign o_ctr_hi = 8'(r_ctr >> 8);
    assign o_rld_lo = r_rld[7:0];
    assign o_rld_hi = 8'(r_rld >> 8);
    assign o_pend   = r_pend;

endmodule

// File: rtl/m2_irq_timer.sv
// Multi-channel m2 IRQ timer: address decode, read muxes, irq OR.
// Ports: m2/map_rst_n; reg_we/addr/wdat/rdat CPU regs; irq_vec/irq;
//  ss_act/we/addr/wdat/rdat save-state access.
module m2_irq_timer
    import m2_irq_timer_pkg::*;
#(
    parameter int CH = 2,
    parameter int CW = 13
) (
    input  logic          m2,
    input  logic          map_rst_n,
    input  logic          reg_we,
    input  logic [4:0]    reg_addr,
    input  logic [7:0]    reg_wdat,
    output logic [7:0]    reg_rdat,
    output logic [CH-1:0] irq_vec,
    output logic          irq,
    input  logic          ss_act,
    input  logic          ss_we,
    input  logic [7:0]    ss_addr,
    input  logic [7:0]    ss_wdat,
    output logic [7:0]    ss_rdat
);

    logic [7:0] w_ctrl   [CH];
    logic [7:0] w_ctr_lo [CH];
    logic [7:0] w_ctr_hi [CH];
    logic [7:0] w_rld_lo [CH];
    logic [7:0] w_rld_hi [CH];

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic w_we, w_ss_we;
        assign w_we    = reg_we && !ss_act &&
                         reg_addr[4:2] == 3'(g);
        assign w_ss_we = ss_we && ss_act &&
                         ss_addr[7:3] == 5'(g);
        m2_irq_timer_ch #(.CW(CW)) u_ch (
            .i_m2      (m2),
            .i_rst_n   (map_rst_n),
            .i_ss_act  (ss_act),
            .i_we      (w_we),
            .i_off     (reg_addr[1:0]),
            .i_wdat    (reg_wdat),
            .i_ss_we   (w_ss_we),
            .i_ss_slot (ss_addr[2:0]),
            .i_ss_wdat (ss_wdat),
            .o_ctrl    (w_ctrl[g]),
            .o_ctr_lo  (w_ctr_lo[g]),
            .o_ctr_hi  (w_ctr_hi[g]),
            .o_rld_lo  (w_rld_lo[g]),
            .o_rld_hi  (w_rld_hi[g]),
            .o_pend    (irq_vec[g])
        );
    end

    always_comb begin
        reg_rdat = 8'hFF;
        for (int i = 0; i < CH; i++) begin
            if (reg_addr[4:2] == 3'(i)) begin
                case (reg_addr[1:0])
                    TMR_CTRL:   reg_rdat = w_ctrl[i];
                    TMR_RLD_LO: reg_rdat = w_rld_lo[i];
                    TMR_RLD_HI: reg_rdat = w_rld_hi[i];
                    default:    reg_rdat = w_ctr_lo[i];
                endcase
            end
        end
    end

    always_comb begin
        ss_rdat = 8'hFF;
        for (int i = 0; i < CH; i++) begin
            if (ss_addr[7:3] == 5'(i)) begin
                case (ss_addr[2:0])
                    SS_CTRL:   ss_rdat = w_ctrl[i];
                    SS_CTR_LO: ss_rdat = w_ctr_lo[i];
                    SS_CTR_HI: ss_rdat = w_ctr_hi[i];
                    SS_RLD_LO: ss_rdat = w_rld_lo[i];
                    SS_RLD_HI: ss_rdat = w_rld_hi[i];
                    default:   ss_rdat = 8'hFF;
                endcase
            end
        end
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_m2_irq_timer.sv
// Bench for m2_irq_timer (CH=2, CW=13).
// Scoreboard of expected values popped against DUT reads.
`timescale 1ns/1ps
module tb_m2_irq_timer;

    localparam int CH = 2;
    localparam int CW = 13;

    logic          m2 = 1'b0;
    logic          map_rst_n = 1'b0;
    logic          reg_we = 1'b0;
    logic [4:0]    reg_addr = '0;
    logic [7:0]    reg_wdat = '0;
    logic [7:0]    reg_rdat;
    logic [CH-1:0] irq_vec;
    logic          irq;
    logic          ss_act = 1'b0;
    logic          ss_we = 1'b0;
    logic [7:0]    ss_addr = '0;
    logic [7:0]    ss_wdat = '0;
    logic [7:0]    ss_rdat;

    m2_irq_timer #(.CH(CH), .CW(CW)) dut (
        .m2        (m2),
        .map_rst_n (map_rst_n),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdat  (reg_wdat),
        .reg_rdat  (reg_rdat),
        .irq_vec   (irq_vec),
        .irq       (irq),
        .ss_act    (ss_act),
        .ss_we     (ss_we),
        .ss_addr   (ss_addr),
        .ss_wdat   (ss_wdat),
        .ss_rdat   (ss_rdat)
    );

    always #10 m2 = ~m2;

    int n_chk = 0;
    int n_pass = 0;

    string       sb_tag[$];
    logic [31:0] sb_exp[$];

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic sb_push(input string t, input logic [31:0] e);
        sb_tag.push_back(t);
        sb_exp.push_back(e);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string t;
        logic [31:0] e;
        if (sb_exp.size() == 0) begin
            chk("sb_underflow", 32'(sb_exp.size()), 32'd1);
        end else begin
            t = sb_tag.pop_front();
            e = sb_exp.pop_front();
            chk(t, obs, e);
        end
    endtask

    task automatic ck_reg(input string t, input logic [4:0] a,
                          input logic [7:0] e);
        sb_push(t, 32'(e));
        reg_addr = a;
        #1;
        sb_pop(32'(reg_rdat));
    endtask

    task automatic ck_ss(input string t, input logic [7:0] a,
                         input logic [7:0] e);
        sb_push(t, 32'(e));
        ss_addr = a;
        #1;
        sb_pop(32'(ss_rdat));
    endtask

    task automatic ck_irq(input string t, input logic [1:0] ev);
        sb_push(t, {29'b0, |ev, ev});
        sb_pop({29'b0, irq, irq_vec});
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        reg_addr = a;
        reg_wdat = d;
        reg_we   = 1'b1;
        @(negedge m2);
        @(posedge m2);
        reg_we   = 1'b0;
    endtask

    task automatic ss_wr(input logic [7:0] a, input logic [7:0] d);
        ss_addr = a;
        ss_wdat = d;
        ss_we   = 1'b1;
        @(negedge m2);
        @(posedge m2);
        ss_we   = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge m2);
    endtask

    initial begin
        int c;
        bit p;
        bit ack;

        // reset state
        repeat (2) @(posedge m2);
        map_rst_n = 1'b1;
        ck_irq("rst_irq", 2'b00);
        ck_reg("rst_ctrl0", 5'h00, 8'h00);
        ck_reg("rst_ctr1", 5'h07, 8'h00);
        ck_ss("rst_rld1", 8'h0B, 8'h00);
        ck_ss("rst_ctrhi0", 8'h02, 8'h00);
        @(posedge m2);

        // 1: legacy up-count to MSB
        wr(5'h00, 8'h01);
        step(4096);
        ck_irq("t1_pre_irq", 2'b00);
        ck_ss("t1_pre_hi", 8'h02, 8'h10);
        ck_reg("t1_pre_lo", 5'h03, 8'h00);
        step(1);
        ck_irq("t1_irq", 2'b01);
        ck_reg("t1_ctrl", 5'h00, 8'h80);
        ck_ss("t1_hi", 8'h02, 8'h10);
        step(2);
        ck_ss("t1_hold_hi", 8'h02, 8'h10);
        ck_irq("t1_hold_irq", 2'b01);
        wr(5'h00, 8'h00);
        ck_irq("t1_clr_irq", 2'b00);
        ck_ss("t1_clr_hi", 8'h02, 8'h00);
        @(posedge m2);

        // 2: ch1 auto-reload with ACKs between pulses
        wr(5'h05, 8'h04);
        wr(5'h06, 8'h00);
        wr(5'h04, 8'h05);
        c = 4;
        p = 1'b0;
        for (int e = 1; e <= 15; e++) begin
            ack = (e == 7) || (e == 12);
            if (ack) begin
                reg_addr = 5'h07;
                reg_wdat = 8'h00;
                reg_we   = 1'b1;
            end
            @(negedge m2);
            if (c == 0) begin
                p = 1'b1;
                c = 4;
            end else begin
                c--;
                if (ack)
                    p = 1'b0;
            end
            @(posedge m2);
            reg_we = 1'b0;
            ck_irq($sformatf("t2_irq_e%0d", e), {p, 1'b0});
            ck_reg($sformatf("t2_ctr_e%0d", e), 5'h07, 8'(c));
        end
        wr(5'h04, 8'h04);
        wr(5'h07, 8'h00);
        ck_irq("t2_stop_irq", 2'b00);
        step(2);
        ck_reg("t2_frozen", 5'h07, 8'h03);
        ck_reg("t2_ctrl", 5'h04, 8'h04);
        @(posedge m2);

        // 3: one-shot, ACK on the terminal edge
        wr(5'h01, 8'h02);
        wr(5'h02, 8'h00);
        wr(5'h00, 8'h03);
        step(2);
        ck_reg("t3_ctr0", 5'h03, 8'h00);
        wr(5'h03, 8'h00);
        ck_irq("t3_irq", 2'b01);
        ck_reg("t3_ctrl", 5'h00, 8'h82);
        ck_reg("t3_ctr", 5'h03, 8'h00);
        step(2);
        ck_reg("t3_hold", 5'h03, 8'h00);
        ck_reg("t3_ctrl2", 5'h00, 8'h82);
        wr(5'h03, 8'h00);
        ck_irq("t3_ack", 2'b00);
        @(posedge m2);

        // 4: async reset mid-count
        wr(5'h05, 8'h00);
        wr(5'h06, 8'h00);
        wr(5'h04, 8'h05);
        wr(5'h01, 8'h25);
        wr(5'h02, 8'h01);
        wr(5'h00, 8'h03);
        step(2);
        ck_reg("t4_pre_lo", 5'h03, 8'h23);
        ck_ss("t4_pre_hi", 8'h02, 8'h01);
        ck_irq("t4_pre_irq", 2'b10);
        @(posedge m2);
        map_rst_n = 1'b0;
        #1;
        ck_irq("t4_rst_irq", 2'b00);
        ck_reg("t4_rst_ctrl0", 5'h00, 8'h00);
        ck_reg("t4_rst_lo0", 5'h03, 8'h00);
        ck_ss("t4_rst_ctrl1", 8'h08, 8'h00);
        map_rst_n = 1'b1;
        step(3);
        ck_reg("t4_idle_lo0", 5'h03, 8'h00);
        ck_ss("t4_idle_hi0", 8'h02, 8'h00);
        ck_irq("t4_idle_irq", 2'b00);
        ck_reg("t4_idle_ctrl1", 5'h04, 8'h00);
        @(posedge m2);

        // 5: save-state write/read, freeze, resume
        ss_act = 1'b1;
        ss_wr(8'h08, 8'h05);
        ss_wr(8'h09, 8'h34);
        ss_wr(8'h0A, 8'h12);
        ss_wr(8'h0B, 8'h10);
        ss_wr(8'h0C, 8'h00);
        ck_ss("t5_s0", 8'h08, 8'h05);
        ck_ss("t5_s1", 8'h09, 8'h34);
        ck_ss("t5_s2", 8'h0A, 8'h12);
        ck_ss("t5_s3", 8'h0B, 8'h10);
        ck_ss("t5_s4", 8'h0C, 8'h00);
        @(posedge m2);
        wr(5'h05, 8'h77);
        step(3);
        ck_ss("t5_frz_lo", 8'h09, 8'h34);
        ck_ss("t5_frz_hi", 8'h0A, 8'h12);
        ck_ss("t5_rld_keep", 8'h0B, 8'h10);
        ck_ss("t5_slot5", 8'h0D, 8'hFF);
        ck_ss("t5_ch2", 8'h10, 8'hFF);
        @(posedge m2);
        ss_act = 1'b0;
        step(1);
        ck_reg("t5_run1", 5'h07, 8'h33);
        ck_ss("t5_run1_hi", 8'h0A, 8'h12);
        step(1);
        ck_reg("t5_run2", 5'h07, 8'h32);
        wr(5'h04, 8'h04);

        // 6: out-of-range channel, RLD_HI width
        wr(5'h16, 8'hFF);
        wr(5'h14, 8'h01);
        ck_reg("t6_rd_ch5", 5'h14, 8'hFF);
        ck_reg("t6_rd_ch7", 5'h1F, 8'hFF);
        ck_ss("t6_ch0_ctrl", 8'h00, 8'h00);
        ck_ss("t6_ch0_rhi", 8'h04, 8'h00);
        ck_ss("t6_ch1_rhi", 8'h0C, 8'h00);
        @(posedge m2);
        wr(5'h02, 8'hFF);
        ck_ss("t6_rld_hi", 8'h04, 8'h1F);
        ck_ss("t6_ctr_hi", 8'h02, 8'h1F);
        ck_irq("t6_irq", 2'b00);

        chk("sb_empty", 32'(sb_exp.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
